// File: rtl/dbscan_stream_ctrl.sv
// Frame controller feeding the DBSCAN magnitude counter: loads a frame with
// insertion sort, streams it in ascending order, then captures the cluster count.
module dbscan_stream_ctrl #(
   parameter int N       = 64,
   parameter int W       = 10,
   parameter int CAP_LAT = 1
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic [W-1:0] in_data_i,
   input  logic         in_valid_i,
   input  logic         in_last_i,
   output logic         in_ready_o,
   output logic [W-1:0] out0_o,
   output logic         start_o,
   output logic         final_o,
   output logic         ds_reset_o,
   input  logic [W-1:0] count_in_i,
   output logic [W-1:0] result_o,
   output logic         result_valid_o,
   output logic         busy_o
);

   // state  | meaning
   // LOAD   | accept samples, insertion-sort into slots
   // PREP   | one-cycle ds_reset strobe to the counter
   // STREAM | out0 = slot[k] with start high, one slot per cycle
   // FINAL  | one-cycle final strobe, out0 holds last value
   // WAIT   | CAP_LAT cycles for the counter to settle
   // DONE   | result_valid pulse, frame storage cleared
   localparam int CW = $clog2(N + 1);
   localparam int IW = $clog2(N);
   localparam int WW = (CAP_LAT > 1) ? $clog2(CAP_LAT) : 1;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_PREP,
      ST_STREAM,
      ST_FINAL,
      ST_WAIT,
      ST_DONE
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   k_q;
   logic [WW-1:0]   wait_q;
   logic [W-1:0]    slot_q [N];
   logic [N-1:0]    valid_q;
   logic [W-1:0]    slot_d [N];
   logic [N-1:0]    valid_d;
   logic [N-1:0]    le;
   logic [W-1:0]    out0_q;
   logic            start_q;
   logic            final_q;
   logic            ds_reset_q;
   logic [W-1:0]    result_q;
   logic            result_valid_q;
   logic            accept;

   assign in_ready_o     = (state_q == ST_LOAD) && (cnt_q < CW'(N));
   assign accept         = in_valid_i && in_ready_o;
   assign busy_o         = (state_q != ST_LOAD);
   assign out0_o         = out0_q;
   assign start_o        = start_q;
   assign final_o        = final_q;
   assign ds_reset_o     = ds_reset_q;
   assign result_o       = result_q;
   assign result_valid_o = result_valid_q;

   // Invalid slots act as +infinity, so the new sample lands after every
   // valid slot that is <= it, which keeps equal values in arrival order.
   always_comb begin
      slot_d  = slot_q;
      valid_d = valid_q;
      le      = '0;
      for (int i = 0; i < N; i++) begin
         le[i] = valid_q[i] && (slot_q[i] <= in_data_i);
      end
      if (!le[0]) begin
         slot_d[0]  = in_data_i;
         valid_d[0] = 1'b1;
      end
      for (int i = 1; i < N; i++) begin
         if (!le[i]) begin
            if (le[i-1]) begin
               slot_d[i]  = in_data_i;
               valid_d[i] = 1'b1;
            end else begin
               slot_d[i]  = slot_q[i-1];
               valid_d[i] = valid_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q        <= ST_LOAD;
         cnt_q          <= '0;
         k_q            <= '0;
         wait_q         <= '0;
         valid_q        <= '0;
         for (int i = 0; i < N; i++) begin
            slot_q[i] <= '0;
         end
         out0_q         <= '0;
         start_q        <= 1'b0;
         final_q        <= 1'b0;
         ds_reset_q     <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (accept) begin
                  slot_q  <= slot_d;
                  valid_q <= valid_d;
                  cnt_q   <= cnt_q + CW'(1);
                  if (in_last_i || (cnt_q == CW'(N - 1))) begin
                     state_q    <= ST_PREP;
                     ds_reset_q <= 1'b1;
                  end
               end
            end
            ST_PREP: begin
               ds_reset_q <= 1'b0;
               start_q    <= 1'b1;
               out0_q     <= slot_q[0];
               k_q        <= CW'(1);
               state_q    <= ST_STREAM;
            end
            ST_STREAM: begin
               if (k_q == cnt_q) begin
                  start_q <= 1'b0;
                  final_q <= 1'b1;
                  state_q <= ST_FINAL;
               end else begin
                  out0_q <= slot_q[k_q[IW-1:0]];
                  k_q    <= k_q + CW'(1);
               end
            end
            ST_FINAL: begin
               final_q <= 1'b0;
               out0_q  <= '0;
               wait_q  <= WW'(CAP_LAT - 1);
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_q == '0) begin
                  result_q       <= count_in_i;
                  result_valid_q <= 1'b1;
                  state_q        <= ST_DONE;
               end else begin
                  wait_q <= wait_q - WW'(1);
               end
            end
            ST_DONE: begin
               result_valid_q <= 1'b0;
               cnt_q          <= '0;
               k_q            <= '0;
               valid_q        <= '0;
               state_q        <= ST_LOAD;
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_dbscan_stream_ctrl.sv
// Directed bench for dbscan_stream_ctrl: sorted-stream scoreboard plus
// strobe timing, result capture and reset-abort checks.
module tb_dbscan_stream_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready_o;
   logic [9:0] out0_o;
   logic       start_o;
   logic       final_o;
   logic       ds_reset_o;
   logic [9:0] count_in;
   logic [9:0] result_o;
   logic       result_valid_o;
   logic       busy_o;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];
   logic [9:0] frame_q[$];

   dbscan_stream_ctrl #(.N(64), .W(10), .CAP_LAT(1)) dut (
      .clk_i(clk),
      .reset_i(reset),
      .in_data_i(in_data),
      .in_valid_i(in_valid),
      .in_last_i(in_last),
      .in_ready_o(in_ready_o),
      .out0_o(out0_o),
      .start_o(start_o),
      .final_o(final_o),
      .ds_reset_o(ds_reset_o),
      .count_in_i(count_in),
      .result_o(result_o),
      .result_valid_o(result_valid_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge.
   task automatic tick();
      int nstrobe;
      @(posedge clk);
      #1;
      if (start_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL out0_extra: observed %0h expected no stream", out0_o);
         end else begin
            chk("out0", out0_o, exp_q.pop_front());
         end
      end else if (!final_o) begin
         chk("out0_idle", out0_o, 0);
      end
      nstrobe = int'(start_o) + int'(final_o) + int'(ds_reset_o);
      chk("strobe_excl", (nstrobe <= 1) ? 1 : 0, 1);
   endtask

   task automatic send(input logic [9:0] d, input logic last);
      bit done = 0;
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      for (int t = 0; t < 400 && !done; t++) begin
         if (in_ready_o) done = 1;
         tick();
      end
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: observed in_ready 0 expected 1");
         return;
      end
      frame_q.push_back(d);
      if (last || frame_q.size() == 64) begin
         frame_q.sort();
         foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
         frame_q.delete();
      end
   endtask

   // Called right after the accept of the last sample of a frame.
   task automatic finish_frame(input int n, input logic [9:0] cv);
      count_in = cv;
      chk("ds_reset", ds_reset_o, 1);
      chk("in_ready_prep", in_ready_o, 0);
      chk("busy_prep", busy_o, 1);
      tick();
      chk("start_first", start_o, 1);
      repeat (n - 1) begin
         tick();
         chk("start_run", start_o, 1);
         chk("in_ready_stream", in_ready_o, 0);
      end
      tick();
      chk("final", final_o, 1);
      chk("start_end", start_o, 0);
      tick();
      chk("final_once", final_o, 0);
      chk("rv_early", result_valid_o, 0);
      tick();
      chk("result_valid", result_valid_o, 1);
      chk("result", result_o, cv);
      chk("in_ready_done", in_ready_o, 0);
      tick();
      chk("rv_pulse", result_valid_o, 0);
      chk("in_ready_load", in_ready_o, 1);
      chk("busy_load", busy_o, 0);
      chk("stream_len", exp_q.size(), 0);
   endtask

   initial begin
      reset    = 1'b1;
      in_data  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      count_in = '0;
      #12;
      reset = 1'b0;
      #1;
      chk("rst_in_ready", in_ready_o, 1);
      chk("rst_out0", out0_o, 0);
      chk("rst_start", start_o, 0);
      chk("rst_final", final_o, 0);
      chk("rst_ds_reset", ds_reset_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_rv", result_valid_o, 0);
      chk("rst_busy", busy_o, 0);

      // Small frame with a duplicate
      send(10'd5, 1'b0);
      send(10'd2, 1'b0);
      send(10'd9, 1'b0);
      send(10'd2, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      finish_frame(4, 10'd7);

      // Full frame, descending, then a sample held across the busy phase
      for (int i = 63; i >= 0; i--) send(10'(i), 1'b0);
      in_data  = 10'h3FF;
      in_valid = 1'b1;
      in_last  = 1'b0;
      finish_frame(64, 10'd3);
      send(10'h3FF, 1'b0);
      send(10'h001, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("result_hold", result_o, 3);
      finish_frame(2, 10'd9);

      // Reset during the third stream cycle
      send(10'd4, 1'b0);
      send(10'd3, 1'b0);
      send(10'd2, 1'b0);
      send(10'd1, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      tick();
      tick();
      chk("pre_abort_start", start_o, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_start", start_o, 0);
      chk("abort_out0", out0_o, 0);
      chk("abort_busy", busy_o, 0);
      chk("abort_result", result_o, 0);
      exp_q.delete();
      frame_q.delete();
      #3;
      reset = 1'b0;
      send(10'd7, 1'b0);
      send(10'd1, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      finish_frame(2, 10'd2);

      // Extreme-value duplicates with idle gaps and a stray in_last
      send(10'h3FF, 1'b0);
      in_valid = 1'b0;
      tick();
      tick();
      send(10'h000, 1'b0);
      in_valid = 1'b0;
      in_last  = 1'b1;
      tick();
      in_last = 1'b0;
      send(10'h3FF, 1'b0);
      send(10'h000, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      finish_frame(4, 10'd5);

      // Single-sample frame
      send(10'h155, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      finish_frame(1, 10'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
